// File: rtl/puzzle_pkg.sv
// Shared 2x3 sliding-puzzle definitions: geometry, move codes, goal board, player FSM states.
// Used by the move player and by the display block's move decode.
package puzzle_pkg;

    localparam int ROWS    = 2;
    localparam int COLS    = 3;
    localparam int CELL_W  = 3;
    localparam int NCELLS  = ROWS * COLS;
    localparam int BOARD_W = NCELLS * CELL_W;

    localparam logic [BOARD_W-1:0] GOAL = 18'o054321;

    typedef enum logic [1:0] {
        MV_UP    = 2'd0,
        MV_DOWN  = 2'd1,
        MV_LEFT  = 2'd2,
        MV_RIGHT = 2'd3
    } move_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_APPLY = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/move_apply.sv
// Applies one move to a board: swaps the blank with its neighbour in direction dir.
// Purely combinational; an illegal move returns the board and blank position unchanged.
module move_apply
    import puzzle_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    input  logic [2:0]         blank_pos,
    input  logic [1:0]         dir,
    output logic [BOARD_W-1:0] next_board,
    output logic [2:0]         next_blank,
    output logic               legal
);

    logic [2:0] target;
    logic [4:0] blank_bit;
    logic [4:0] target_bit;

    always_comb begin
        legal  = 1'b0;
        target = blank_pos;
        case (move_t'(dir))
            MV_UP: begin
                legal  = (blank_pos >= 3'd3) && (blank_pos <= 3'd5);
                target = blank_pos - 3'd3;
            end
            MV_DOWN: begin
                legal  = (blank_pos <= 3'd2);
                target = blank_pos + 3'd3;
            end
            MV_LEFT: begin
                legal  = (blank_pos == 3'd1) || (blank_pos == 3'd2) ||
                         (blank_pos == 3'd4) || (blank_pos == 3'd5);
                target = blank_pos - 3'd1;
            end
            default: begin
                legal  = (blank_pos == 3'd0) || (blank_pos == 3'd1) ||
                         (blank_pos == 3'd3) || (blank_pos == 3'd4);
                target = blank_pos + 3'd1;
            end
        endcase

        blank_bit  = {2'b00, blank_pos} * 5'd3;
        target_bit = {2'b00, target} * 5'd3;
        next_board = board;
        next_blank = blank_pos;
        if (legal) begin
            next_board[blank_bit +: CELL_W]  = board[target_bit +: CELL_W];
            next_board[target_bit +: CELL_W] = '0;
            next_blank = target;
        end
    end

endmodule

// File: rtl/move_player.sv
// Plays a latched move list onto the live board, one move per step-button edge or auto tick.
// Step edge in WAIT at cycle n updates board/num at the edge ending cycle n+1; presses outside WAIT are dropped.
module move_player
    import puzzle_pkg::*;
#(
    parameter logic [23:0] TICK_DIV  = 24'd12_000_000,
    parameter int          MAX_MOVES = 20
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [BOARD_W-1:0]     board_init,
    input  logic [2*MAX_MOVES-1:0] ord,
    input  logic [4:0]             cnt,
    input  logic                   step_btn,
    input  logic                   auto_en,
    output logic [BOARD_W-1:0]     board,
    output logic [4:0]             num,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   solved
);

    state_t                 state;
    logic [2*MAX_MOVES-1:0] ord_q;
    logic [4:0]             cnt_q;
    logic [2:0]             blank_pos;
    logic [23:0]            tick;
    logic                   btn_flag;

    logic [2:0]             zero_cnt;
    logic                   bad_val;
    logic [2:0]             scan_pos;
    logic                   load_bad;
    logic                   step_evt;
    logic [1:0]             cur_dir;
    logic [BOARD_W-1:0]     nxt_board;
    logic [2:0]             nxt_blank;
    logic                   mv_legal;

    // Validate the incoming board while it is being latched in LOAD.
    always_comb begin
        zero_cnt = '0;
        bad_val  = 1'b0;
        scan_pos = '0;
        for (int i = 0; i < NCELLS; i++) begin
            if (board_init[i*CELL_W +: CELL_W] == '0) begin
                zero_cnt = zero_cnt + 3'd1;
                scan_pos = 3'(i);
            end
            if (board_init[i*CELL_W +: CELL_W] > 3'd5)
                bad_val = 1'b1;
        end
    end

    assign load_bad = (zero_cnt != 3'd1) || bad_val || (cnt > 5'(MAX_MOVES));
    assign step_evt = (step_btn && !btn_flag) || (auto_en && (tick == TICK_DIV - 24'd1));
    assign cur_dir  = ord_q[{num, 1'b0} +: 2];
    assign solved   = (board == GOAL);

    move_apply u_move_apply (
        .board      (board),
        .blank_pos  (blank_pos),
        .dir        (cur_dir),
        .next_board (nxt_board),
        .next_blank (nxt_blank),
        .legal      (mv_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            board     <= GOAL;
            num       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            tick      <= '0;
            btn_flag  <= 1'b0;
            ord_q     <= '0;
            cnt_q     <= '0;
            blank_pos <= 3'd5;
        end else begin
            // Level tracker runs in every state so a held button cannot fire on entering WAIT.
            btn_flag <= step_btn;
            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
                err   <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        board     <= board_init;
                        ord_q     <= ord;
                        cnt_q     <= cnt;
                        blank_pos <= scan_pos;
                        tick      <= '0;
                        if (load_bad) begin
                            state <= ST_ERR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else if (cnt == '0) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (!auto_en || step_evt)
                            tick <= '0;
                        else
                            tick <= tick + 24'd1;
                        if (step_evt)
                            state <= ST_APPLY;
                    end
                    ST_APPLY: begin
                        tick <= '0;
                        if (mv_legal) begin
                            board     <= nxt_board;
                            blank_pos <= nxt_blank;
                            num       <= num + 5'd1;
                            if (num + 5'd1 == cnt_q) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end else begin
                            state <= ST_ERR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end
                    default: begin
                        if (start) begin
                            state <= ST_LOAD;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            err   <= 1'b0;
                            num   <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_player.sv
// Directed-vector bench for move_player with a short auto-step period.
module tb_move_player;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [17:0] board_init = 18'o054321;
    logic [39:0] ord = '0;
    logic [4:0]  cnt = '0;
    logic        step_btn = 1'b0;
    logic        auto_en = 1'b0;
    logic [17:0] board;
    logic [4:0]  num;
    logic        busy;
    logic        done;
    logic        err;
    logic        solved;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [17:0] B_GOAL = 18'o054321;
    localparam logic [17:0] B_L1   = 18'o504321;

    move_player #(.TICK_DIV(24'd4), .MAX_MOVES(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .board_init (board_init),
        .ord        (ord),
        .cnt        (cnt),
        .step_btn   (step_btn),
        .auto_en    (auto_en),
        .board      (board),
        .num        (num),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .solved     (solved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one cycle; returns at the negedge where the FSM sits in LOAD.
    task automatic kick(input logic [17:0] b, input logic [39:0] o, input logic [4:0] c);
        board_init = b;
        ord        = o;
        cnt        = c;
        start      = 1'b1;
        cyc(1);
        start      = 1'b0;
    endtask

    task automatic press;
        step_btn = 1'b1;
        cyc(1);
        step_btn = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("rst_board", board, B_GOAL);
        chk("rst_num", num, 0);
        chk("rst_flags", {busy, done, err}, 0);
        chk("rst_solved", solved, 1);
        rst_n = 1'b1;
        cyc(1);

        // Manual single step: RIGHT from blank at cell 4 solves the board.
        kick(B_L1, 40'h3, 5'd1);
        chk("man_busy_load", busy, 1);
        cyc(1);
        chk("man_board_loaded", board, B_L1);
        chk("man_unsolved", solved, 0);
        cyc(3);
        chk("man_no_step_yet", num, 0);
        press;
        chk("man_apply_num", num, 0);
        cyc(1);
        chk("man_board", board, B_GOAL);
        chk("man_num", num, 1);
        chk("man_done", {busy, done, err}, 3'b010);
        chk("man_solved", solved, 1);

        // Illegal move: RIGHT with blank at cell 5.
        kick(B_GOAL, 40'h3, 5'd1);
        chk("ill_done_cleared", done, 0);
        cyc(1);
        press;
        cyc(1);
        chk("ill_err", {busy, done, err}, 3'b001);
        chk("ill_num", num, 0);
        chk("ill_board", board, B_GOAL);

        // Auto playback: LEFT then RIGHT, tick period 4.
        auto_en = 1'b1;
        kick(B_GOAL, 40'hE, 5'd2);
        chk("auto_err_cleared", err, 0);
        cyc(5);
        chk("auto_apply0_num", num, 0);
        chk("auto_apply0_busy", busy, 1);
        cyc(1);
        chk("auto_step1_num", num, 1);
        chk("auto_step1_board", board, B_L1);
        cyc(4);
        chk("auto_apply1_num", num, 1);
        chk("auto_apply1_done", done, 0);
        cyc(1);
        chk("auto_done", {busy, done, err}, 3'b010);
        chk("auto_num", num, 2);
        chk("auto_board", board, B_GOAL);
        chk("auto_solved", solved, 1);
        auto_en = 1'b0;

        // Bad loads.
        kick(18'o000321, 40'h3, 5'd1);
        cyc(1);
        chk("bad_blanks_err", {busy, done, err}, 3'b001);
        chk("bad_blanks_num", num, 0);
        chk("bad_blanks_board", board, 18'o000321);
        kick(B_GOAL, 40'h0, 5'd21);
        cyc(1);
        chk("bad_cnt_err", {busy, done, err}, 3'b001);
        kick(18'o064321, 40'h0, 5'd1);
        cyc(1);
        chk("bad_val_err", err, 1);
        kick(B_GOAL, 40'h0, 5'd20);
        cyc(1);
        chk("cnt20_wait", {busy, done, err}, 3'b100);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        kick(B_L1, 40'h0, 5'd0);
        cyc(1);
        chk("cnt0_done", {busy, done, err}, 3'b010);
        chk("cnt0_board", board, B_L1);

        // Held button through start must not step until re-pressed.
        step_btn = 1'b1;
        kick(B_GOAL, 40'hE, 5'd2);
        cyc(4);
        chk("held_no_step", num, 0);
        chk("held_busy", busy, 1);
        step_btn = 1'b0;
        cyc(2);
        chk("release_no_step", num, 0);
        press;
        cyc(1);
        chk("repress_num", num, 1);
        chk("repress_board", board, B_L1);

        // Abort from WAIT, and abort beating start.
        abort = 1'b1;
        start = 1'b1;
        cyc(1);
        chk("abort_busy", {busy, done, err}, 0);
        chk("abort_board", board, B_L1);
        chk("abort_num", num, 1);
        cyc(1);
        chk("abort_wins", busy, 0);
        abort = 1'b0;
        start = 1'b0;
        cyc(1);

        // Asynchronous reset while waiting for a step.
        kick(B_L1, 40'h3, 5'd1);
        cyc(2);
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_board", board, B_GOAL);
        chk("arst_num", num, 0);
        chk("arst_flags", {busy, done, err}, 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/move_player.md
Name: move_player

Overview:
- Playback controller for the solver's move list.
- Latches a start board (2x3 puzzle, 5 tiles plus blank), a move order `ord` and a move count `cnt`, then applies the moves one at a time, either on manual step-button edges or on an auto-step timer.
- Drives the live board register and the step index `num` consumed by the display block.
- Flags illegal moves and reports whether the final board is solved.

Parameters:
TICK_DIV, 24'd12_000_000, auto-step period in clk cycles (minimum 2)
MAX_MOVES, 20, capacity of `ord` (2 bits per move)
GOAL, 18'o054321, solved board: cells 0..4 hold tiles 1..5, cell 5 holds blank

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; sampled in IDLE/DONE/ERR to begin a playback
abort  in  1  return to IDLE from any state
board_init  in  18  start board; cell i at [3i+2:3i], blank=0
ord  in  40  move list; move k at [2k+1:2k]
cnt  in  5  number of moves to play
step_btn  in  1  manual step (synchronised upstream, not debounced here)
auto_en  in  1  enable auto-step timer
board  out  18  current board
num  out  5  moves applied so far
busy  out  1  state is LOAD, WAIT or APPLY
done  out  1  all cnt moves applied
err  out  1  illegal move or bad load
solved  out  1  board == GOAL (combinational from board register)

Behaviour:
- Reset values: board=GOAL, num=0, busy=0, done=0, err=0, FSM=IDLE, tick=0, btn_flag=0.
- Reset is asynchronous on all flops.
- Move encoding: 0=UP (blank i->i-3, legal if i>=3); 1=DOWN (i->i+3, legal if i<=2); 2=LEFT (i->i-1, legal if i%3!=0); 3=RIGHT (i->i+1, legal if i%3!=2).
- Applying a move swaps the blank with the target cell.
- FSM states: IDLE, LOAD, WAIT, APPLY, DONE, ERR.
- IDLE/DONE/ERR with start=1: go to LOAD next cycle; clear done, err and num.
- LOAD (1 cycle): latch board_init into board, ord into ord_q, cnt into cnt_q; scan for the blank into blank_pos (3 bits).
  - Not exactly one zero cell, any cell value >5, or cnt>MAX_MOVES: go to ERR with board still loaded.
  - cnt==0: go to DONE.
  - Otherwise: go to WAIT.
- Later changes on board_init, ord and cnt are ignored until the next LOAD.
- WAIT: step event = rising edge of step_btn (btn_flag set on press, cleared when released) OR (auto_en && tick==TICK_DIV-1).
  - tick increments each WAIT cycle while auto_en=1.
  - tick clears on entering WAIT, on any step event, and whenever auto_en=0.
  - On an event, go to APPLY.
- APPLY (1 cycle): decode move ord_q[2*num+1 : 2*num].
  - Legal move: swap cells, update blank_pos, num<=num+1; go to DONE if num+1==cnt_q, else WAIT.
  - Illegal move: board and num unchanged; go to ERR.
- Step presses outside WAIT are ignored, but btn_flag still tracks the button level, so a held button does not fire on entering WAIT.
- DONE: done=1, board and num hold. ERR: err=1, board and num hold (num = index of the failing move).
- abort: next state IDLE from any state. board and num hold, done=0, err=0.
- abort and start asserted together: abort wins.
- Latency: step edge in WAIT at cycle n -> board and num updated at the edge ending cycle n+1.

Decomposition:
- Shared package puzzle_pkg:
  - move encodings MV_UP/MV_DOWN/MV_LEFT/MV_RIGHT (also used by the display block's UE/SHITA/HIDARI/MIGI decode);
  - board geometry constants ROWS=2, COLS=3, CELL_W=3;
  - GOAL constant;
  - FSM state enum.
- One sub-module, move_apply: combinational (board, blank_pos, dir) -> (next_board, next_blank, legal).

Test Plan:
- Reset mid-playback: assert rst_n=0 while in WAIT -> immediately board=18'o054321, num=0, busy=0, done=0, err=0.
- Manual single step: board_init=18'o504321, ord=40'h3, cnt=1, start pulse, one step_btn press -> board=18'o054321, num=1, done=1, solved=1.
- Illegal move: board_init=GOAL, ord=40'h3 (RIGHT with blank at cell 5), cnt=1, step -> err=1, num=0, board unchanged, done=0.
- Auto playback: TICK_DIV=4, board_init=GOAL, ord=40'hE (LEFT, then RIGHT), cnt=2, auto_en=1 -> num=1 with board=18'o504321 at the APPLY after 4 WAIT cycles, then done=1 with board=GOAL, solved=1.
- Bad load: board_init=18'o000321 (three blanks), or cnt=21 -> ERR after LOAD, num=0.
- Held button and abort: hold step_btn through start -> no step until release and re-press; assert abort while in WAIT -> IDLE, board held, busy=0.
